// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the change dispenser and the vending FSM that feeds it.
package change_dispenser_pkg;

  localparam int unsigned NICKEL_W  = 5;
  localparam int unsigned DIME_W    = 4;
  localparam int unsigned QUARTER_W = 2;
  localparam int unsigned CENTS_W   = 9;
  localparam int unsigned TMR_W     = 8;
  localparam int unsigned GAP_W     = 4;

  localparam int unsigned NICKEL_CENTS  = 5;
  localparam int unsigned DIME_CENTS    = 10;
  localparam int unsigned QUARTER_CENTS = 25;
  localparam int unsigned DOLLAR_CENTS  = 100;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_SELECT     = 3'd1;
  localparam logic [2:0] ST_PULSE      = 3'd2;
  localparam logic [2:0] ST_WAIT_SENSE = 3'd3;
  localparam logic [2:0] ST_GAP        = 3'd4;
  localparam logic [2:0] ST_DONE       = 3'd5;
  localparam logic [2:0] ST_FAULT      = 3'd6;

  typedef enum logic [2:0] {
    SEL_DOLLAR  = 3'd0,
    SEL_QUARTER = 3'd1,
    SEL_DIME    = 3'd2,
    SEL_NICKEL  = 3'd3,
    SEL_NONE    = 3'd4
  } coin_sel_e;

  typedef struct packed {
    logic                 dol;
    logic [QUARTER_W-1:0] q;
    logic [DIME_W-1:0]    d;
    logic [NICKEL_W-1:0]  n;
  } coin_counts_t;

endpackage

// File: rtl/change_dispenser_if.sv
// Job/hopper bundle between the vending FSM, the change dispenser and the coin hopper.
interface change_dispenser_if;
  import change_dispenser_pkg::*;

  logic                 load;
  logic [NICKEL_W-1:0]  nickels_in;
  logic [DIME_W-1:0]    dimes_in;
  logic [QUARTER_W-1:0] quarters_in;
  logic                 dollar_in;
  logic                 coin_sensed;
  logic                 fault_clr;
  logic                 eject_dollar;
  logic                 eject_quarter;
  logic                 eject_dime;
  logic                 eject_nickel;
  logic                 busy;
  logic                 done;
  logic                 fault;
  logic [CENTS_W-1:0]   remaining_cents;

  modport master (
    output load, nickels_in, dimes_in, quarters_in, dollar_in, coin_sensed, fault_clr,
    input  eject_dollar, eject_quarter, eject_dime, eject_nickel, busy, done, fault,
           remaining_cents
  );

  modport slave (
    input  load, nickels_in, dimes_in, quarters_in, dollar_in, coin_sensed, fault_clr,
    output eject_dollar, eject_quarter, eject_dime, eject_nickel, busy, done, fault,
           remaining_cents
  );

endinterface

// File: rtl/change_value_calc.sv
// Combinational cent value of a coin breakdown; max 100+75+150+155 = 480 fits in 9 bits.
module change_value_calc
  import change_dispenser_pkg::*;
(
  input  coin_counts_t       counts,
  output logic [CENTS_W-1:0] cents_c
);

  always_comb begin
    cents_c = CENTS_W'(DOLLAR_CENTS)  * CENTS_W'(counts.dol)
            + CENTS_W'(QUARTER_CENTS) * CENTS_W'(counts.q)
            + CENTS_W'(DIME_CENTS)    * CENTS_W'(counts.d)
            + CENTS_W'(NICKEL_CENTS)  * CENTS_W'(counts.n);
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a latched change breakdown one coin at a time, highest value first,
// confirming each coin with the hopper drop sensor and latching a fault on a missed drop.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               rst_n,
  change_dispenser_if.slave bus
);

  localparam logic [TMR_W-1:0] PULSE_LAST   = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST     = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  // With no gap configured a confirmed coin goes straight back to selection.
  localparam logic [2:0]       AFTER_COIN   = (GAP_CYCLES == 0) ? ST_SELECT : ST_GAP;

  logic [2:0]         state, state_n;
  coin_counts_t       counts, counts_n;
  coin_sel_e          sel, sel_n, pick;
  logic               sensed, sensed_n;
  logic [TMR_W-1:0]   tmr, tmr_n;
  logic [GAP_W-1:0]   gap_cnt, gap_n;
  logic               dec;
  logic [CENTS_W-1:0] cents_n_c;

  change_value_calc u_calc (
    .counts  (counts_n),
    .cents_c (cents_n_c)
  );

  // Next-state, counter and count update logic.
  always_comb begin
    state_n  = state;
    counts_n = counts;
    sel_n    = sel;
    sensed_n = sensed;
    tmr_n    = tmr;
    gap_n    = gap_cnt;
    pick     = SEL_NONE;
    dec      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.load) begin
          counts_n.dol = bus.dollar_in;
          counts_n.q   = bus.quarters_in;
          counts_n.d   = bus.dimes_in;
          counts_n.n   = bus.nickels_in;
          state_n      = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (counts.dol)              pick = SEL_DOLLAR;
        else if (counts.q != '0)     pick = SEL_QUARTER;
        else if (counts.d != '0)     pick = SEL_DIME;
        else if (counts.n != '0)     pick = SEL_NICKEL;
        sel_n    = pick;
        sensed_n = 1'b0;
        tmr_n    = '0;
        gap_n    = '0;
        state_n  = (pick == SEL_NONE) ? ST_DONE : ST_PULSE;
      end
      ST_PULSE: begin
        tmr_n = tmr + TMR_W'(1);
        // An early drop is credited once; the strobe still runs its full width.
        if (bus.coin_sensed && !sensed) begin
          dec      = 1'b1;
          sensed_n = 1'b1;
        end
        if (tmr == PULSE_LAST) begin
          state_n = sensed_n ? AFTER_COIN : ST_WAIT_SENSE;
        end
      end
      ST_WAIT_SENSE: begin
        tmr_n = tmr + TMR_W'(1);
        if (bus.coin_sensed) begin
          dec      = 1'b1;
          sensed_n = 1'b1;
          state_n  = AFTER_COIN;
        end else if (tmr >= TIMEOUT_LAST) begin
          state_n = ST_FAULT;
        end
      end
      ST_GAP: begin
        gap_n = gap_cnt + GAP_W'(1);
        if (gap_cnt == GAP_LAST) state_n = ST_SELECT;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      ST_FAULT: begin
        if (bus.fault_clr) begin
          counts_n = '0;
          state_n  = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    if (dec) begin
      case (sel)
        SEL_DOLLAR:  counts_n.dol = 1'b0;
        SEL_QUARTER: counts_n.q   = counts.q - QUARTER_W'(1);
        SEL_DIME:    counts_n.d   = counts.d - DIME_W'(1);
        SEL_NICKEL:  counts_n.n   = counts.n - NICKEL_W'(1);
        default:     ;
      endcase
    end
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_IDLE;
      counts              <= '0;
      sel                 <= SEL_NONE;
      sensed              <= 1'b0;
      tmr                 <= '0;
      gap_cnt             <= '0;
      bus.eject_dollar    <= 1'b0;
      bus.eject_quarter   <= 1'b0;
      bus.eject_dime      <= 1'b0;
      bus.eject_nickel    <= 1'b0;
      bus.busy            <= 1'b0;
      bus.done            <= 1'b0;
      bus.fault           <= 1'b0;
      bus.remaining_cents <= '0;
    end else begin
      state               <= state_n;
      counts              <= counts_n;
      sel                 <= sel_n;
      sensed              <= sensed_n;
      tmr                 <= tmr_n;
      gap_cnt             <= gap_n;
      bus.eject_dollar    <= (state_n == ST_PULSE) && (sel_n == SEL_DOLLAR);
      bus.eject_quarter   <= (state_n == ST_PULSE) && (sel_n == SEL_QUARTER);
      bus.eject_dime      <= (state_n == ST_PULSE) && (sel_n == SEL_DIME);
      bus.eject_nickel    <= (state_n == ST_PULSE) && (sel_n == SEL_NICKEL);
      bus.busy            <= (state_n != ST_IDLE);
      bus.done            <= (state_n == ST_DONE);
      bus.fault           <= (state_n == ST_FAULT);
      bus.remaining_cents <= cents_n_c;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: a table of complete jobs plus reset and timeout sequences.
module tb_change_dispenser;
  import change_dispenser_pkg::*;

  localparam int unsigned PULSE = 4;
  localparam int unsigned GAP   = 2;
  localparam int unsigned TMO   = 255;
  localparam int          BUDGET = 400;

  typedef struct {
    int id;
    int dol, q, d, n;
    int delay;      // cycles from strobe rise to sensor pulse
    int dbl;        // second sensor pulse 2 cycles after the first
    int poke;       // cycle at which a stray load (q=3, dol=1) is driven, 0 = none
    int exp_cents;
    int exp_done;   // cycles from load to done
    int exp_nd, exp_nq, exp_ndm, exp_nn;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  vec_t tbl[9];

  change_dispenser_if bus();

  change_dispenser #(
    .PULSE_CYCLES   (PULSE),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string what, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", what, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.load        = 1'b0;
    bus.nickels_in  = '0;
    bus.dimes_in    = '0;
    bus.quarters_in = '0;
    bus.dollar_in   = 1'b0;
    bus.coin_sensed = 1'b0;
    bus.fault_clr   = 1'b0;
  endtask

  function automatic logic [3:0] ej();
    return {bus.eject_dollar, bus.eject_quarter, bus.eject_dime, bus.eject_nickel};
  endfunction

  function automatic int all_outs();
    return int'({ej(), bus.busy, bus.done, bus.fault});
  endfunction

  function automatic int type_of(input logic [3:0] e);
    if (e[3]) return 0;
    if (e[2]) return 1;
    if (e[1]) return 2;
    return 3;
  endfunction

  function automatic int value_of(input int ty);
    case (ty)
      0:       return 100;
      1:       return 25;
      2:       return 10;
      default: return 5;
    endcase
  endfunction

  task automatic run_job(input vec_t v);
    int done_at = -1;
    int cnt[4] = '{0, 0, 0, 0};
    int cd = -1;
    int cd2 = -1;
    int run = 0;
    int last = 0;
    int prev_c = 0;
    int ty;
    logic [3:0] e;
    logic [3:0] pe = 4'b0;
    bus.dollar_in   = v.dol[0];
    bus.quarters_in = 2'(v.q);
    bus.dimes_in    = 4'(v.d);
    bus.nickels_in  = 5'(v.n);
    bus.load        = 1'b1;
    for (int c = 1; c <= BUDGET && done_at < 0; c++) begin
      tick();
      e = ej();
      if (c == 1)
        chk($sformatf("row%0d cents_after_load", v.id), int'(bus.remaining_cents), v.exp_cents);
      else if (int'(bus.remaining_cents) != prev_c)
        chk($sformatf("row%0d cents_step", v.id), int'(bus.remaining_cents), prev_c - value_of(last));
      prev_c = int'(bus.remaining_cents);
      if (e != 4'b0 && pe == 4'b0) begin
        ty = type_of(e);
        chk($sformatf("row%0d onehot", v.id), $countones(e), 1);
        chk($sformatf("row%0d order", v.id), (ty >= last) ? 1 : 0, 1);
        last = ty;
        cnt[ty]++;
        run = 1;
        cd  = v.delay;
        cd2 = (v.dbl != 0) ? v.delay + 2 : -1;
      end else if (e != 4'b0) begin
        run++;
        if ($countones(e) > 1) chk($sformatf("row%0d onehot", v.id), $countones(e), 1);
      end else if (pe != 4'b0) begin
        chk($sformatf("row%0d strobe_width", v.id), run, int'(PULSE));
      end
      if (bus.done) begin
        done_at = c;
        chk($sformatf("row%0d busy_at_done", v.id), int'(bus.busy), 1);
        chk($sformatf("row%0d cents_at_done", v.id), int'(bus.remaining_cents), 0);
      end
      // Inputs for cycle c.
      bus.load = (c == v.poke);
      if (c == v.poke) begin
        bus.quarters_in = 2'd3;
        bus.dollar_in   = 1'b1;
      end
      bus.coin_sensed = (cd == 0 || cd2 == 0);
      if (cd >= 0) cd--;
      if (cd2 >= 0) cd2--;
      pe = e;
    end
    drive_idle();
    chk($sformatf("row%0d done_cycle", v.id), done_at, v.exp_done);
    chk($sformatf("row%0d n_dollar", v.id), cnt[0], v.exp_nd);
    chk($sformatf("row%0d n_quarter", v.id), cnt[1], v.exp_nq);
    chk($sformatf("row%0d n_dime", v.id), cnt[2], v.exp_ndm);
    chk($sformatf("row%0d n_nickel", v.id), cnt[3], v.exp_nn);
    tick();
    chk($sformatf("row%0d busy_after_done", v.id), int'(bus.busy), 0);
    chk($sformatf("row%0d done_one_cycle", v.id), int'(bus.done), 0);
    tick();
  endtask

  initial begin
    int s;
    int f;
    int w;
    int rises;
    int stray;
    logic [3:0] e;
    logic [3:0] pe;

    //         id dol q  d  n  dly dbl poke cents done nd nq ndm nn
    tbl[0] = '{0, 1, 1, 1, 0, 1, 0, 0, 135, 23, 1, 1, 1, 0};
    tbl[1] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0};
    tbl[2] = '{2, 0, 3, 0, 1, 1, 0, 0, 80, 30, 0, 3, 0, 1};
    tbl[3] = '{3, 0, 0, 2, 1, 3, 0, 0, 25, 23, 0, 0, 2, 1};
    tbl[4] = '{4, 0, 0, 0, 1, 6, 0, 0, 5, 12, 0, 0, 0, 1};
    tbl[5] = '{5, 0, 2, 0, 0, 4, 0, 0, 50, 18, 0, 2, 0, 0};
    tbl[6] = '{6, 0, 0, 0, 3, 0, 1, 0, 15, 23, 0, 0, 0, 3};
    tbl[7] = '{7, 0, 0, 1, 1, 1, 0, 3, 15, 16, 0, 0, 1, 1};
    tbl[8] = '{8, 1, 3, 15, 31, 0, 0, 0, 480, 352, 1, 3, 15, 31};

    drive_idle();
    rst_n = 1'b0;
    tick();
    tick();
    chk("reset_outputs", all_outs(), 0);
    chk("reset_cents", int'(bus.remaining_cents), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_job(tbl[i]);

    // Asynchronous reset while the quarter strobe is high.
    bus.quarters_in = 2'd2;
    bus.load        = 1'b1;
    w = 0;
    for (int c = 0; c < 20 && !bus.eject_quarter; c++) begin
      tick();
      bus.load = 1'b0;
      w++;
    end
    chk("rst_reach_quarter", int'(bus.eject_quarter), 1);
    drive_idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", all_outs(), 0);
    chk("rst_async_cents", int'(bus.remaining_cents), 0);
    tick();
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (all_outs() != 0 || bus.remaining_cents != '0) stray++;
    end
    chk("rst_no_resume", stray, 0);

    // Missed drop: nickel strobe with no sensor answer, then stray load and fault_clr.
    bus.nickels_in = 5'd2;
    bus.load       = 1'b1;
    s = -1;
    f = -1;
    w = 0;
    rises = 0;
    pe = 4'b0;
    for (int c = 1; c <= BUDGET && f < 0; c++) begin
      tick();
      bus.load = 1'b0;
      e = ej();
      if (e != 4'b0 && pe == 4'b0) begin
        rises++;
        if (s < 0) s = c;
      end
      if (bus.eject_nickel) w++;
      if (bus.fault) f = c;
      pe = e;
    end
    drive_idle();
    chk("tmo_strobes", rises, 1);
    chk("tmo_nickel_width", w, int'(PULSE));
    chk("tmo_fault_delay", f - s, int'(TMO));
    chk("tmo_cents_held", int'(bus.remaining_cents), 10);
    chk("tmo_busy", int'(bus.busy), 1);
    bus.quarters_in = 2'd3;
    bus.load        = 1'b1;
    tick();
    drive_idle();
    tick();
    chk("tmo_load_ignored", int'(bus.remaining_cents), 10);
    chk("tmo_fault_held", int'(bus.fault), 1);
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    chk("clr_fault", int'(bus.fault), 0);
    chk("clr_busy", int'(bus.busy), 0);
    chk("clr_cents", int'(bus.remaining_cents), 0);
    stray = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.done) stray++;
      tick();
    end
    chk("clr_no_done", stray, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream stage of the vending FSM: accepts the change breakdown it produces (dollar, quarters, dimes, nickels) and drives the coin-hopper solenoids one coin at a time.
- Each coin ejection is confirmed by the hopper's drop sensor.
- Reports busy/done status, remaining change in cents, and a latched fault on a missed drop.

Parameters:
- PULSE_CYCLES, 4: cycles each eject strobe stays high (range 1..15).
- GAP_CYCLES, 2: idle cycles between consecutive coins (range 0..15).
- TIMEOUT_CYCLES, 255: maximum cycles from eject-strobe start to coin_sensed before fault (range 1..255, must exceed PULSE_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  single-cycle strobe; latch the change counts.
- nickels_in  in  5  nickels to return (0..31).
- dimes_in  in  4  dimes to return (0..15).
- quarters_in  in  2  quarters to return (0..3).
- dollar_in  in  1  one dollar coin to return.
- coin_sensed  in  1  hopper drop sensor; one-cycle pulse per coin, synchronous to clk.
- fault_clr  in  1  clears a latched fault.
- eject_dollar  out  1  dollar hopper strobe.
- eject_quarter  out  1  quarter hopper strobe.
- eject_dime  out  1  dime hopper strobe.
- eject_nickel  out  1  nickel hopper strobe.
- busy  out  1  high while a job is in progress.
- done  out  1  one-cycle pulse when a job completes.
- fault  out  1  latched timeout indication.
- remaining_cents  out  9  cents still to dispense (maximum 480).

Behaviour:
- Reset (asynchronous, any state): all outputs 0, all counts 0, state IDLE. Reset mid-job abandons the job; no coin is resumed.
- States: IDLE, SELECT, PULSE, WAIT_SENSE, GAP, DONE, FAULT.
- IDLE:
  - load=1 latches the four counts; state goes to SELECT; busy=1 from the next cycle.
  - remaining_cents = 100*dol + 25*q + 10*d + 5*n, computed from the latched counts every cycle (9-bit, no overflow).
- load outside IDLE is ignored; the latched counts are unchanged.
- SELECT (1 cycle): pick the highest-value nonzero count, in the order dollar > quarter > dime > nickel.
  - If all counts are zero, go to DONE.
- PULSE:
  - Exactly one eject_* line is high, for PULSE_CYCLES cycles.
  - The timeout counter starts at the first PULSE cycle.
  - coin_sensed during PULSE is recorded and still completes the full pulse.
  - Then go to GAP if already sensed, otherwise WAIT_SENSE.
- WAIT_SENSE: all eject_* low.
  - coin_sensed goes to GAP.
  - Timeout counter reaching TIMEOUT_CYCLES goes to FAULT.
- Decrement rule: the selected count decrements by 1 in the cycle coin_sensed is sampled. Extra coin_sensed pulses within the same coin are ignored.
- GAP: GAP_CYCLES idle cycles (0 means pass straight through), then SELECT.
- DONE (1 cycle): done=1, busy=1. Then IDLE with busy=0.
  - A zero-count load gives done 2 cycles after load, with no strobes.
- FAULT:
  - fault=1, busy=1, all eject_* low.
  - Remaining counts are held, so remaining_cents shows the undispensed value.
  - fault_clr: clear the counts, go to IDLE with fault=0, busy=0, and no done pulse.
  - load is ignored in FAULT.
- coin_sensed in IDLE, SELECT, GAP, DONE or FAULT is ignored.
- At most one eject_* is high in any cycle. All outputs are registered.
- Latency for 1 coin with sensor response in PULSE: load at edge k; strobe high k+2 .. k+1+PULSE_CYCLES; done at k+3+PULSE_CYCLES+GAP_CYCLES.

Decomposition:
- Shared package holds:
  - coin value constants: 5, 10, 25, 100;
  - state enum;
  - coin-select encoding: DOLLAR, QUARTER, DIME, NICKEL, NONE.
- One sub-module, change_value_calc: combinational cents computation from the four counts. It is reusable by the vending FSM.
- Timer and counters stay inline.

Test Plan:
- Reset mid-PULSE (rst_n low for 1 cycle during eject_quarter) -> all outputs 0 immediately, state IDLE, remaining_cents=0.
- Load dol=1, q=1, d=1, n=0 (PULSE=4, GAP=2), sensor answers 1 cycle after each strobe rises:
  - strobe order is dollar, quarter, dime, each 4 cycles wide;
  - remaining_cents steps 135 -> 35 -> 10 -> 0;
  - one done pulse; busy falls the cycle after done.
- Load all zero -> no strobes; done=1 two cycles after load; remaining_cents stays 0.
- Load n=2, no sensor response -> eject_nickel for 4 cycles, fault=1 at 255 cycles after strobe start, remaining_cents=10.
  - Then fault_clr -> IDLE, fault=0, busy=0, remaining_cents=0, no done.
- Load during busy with q=3 mid-job -> ignored; the original job completes with its counts unchanged.
- Double coin_sensed in one PULSE (n=3) -> count decrements once per coin; exactly 3 nickel strobes; remaining_cents 15 -> 10 -> 5 -> 0.
